// File: rtl/types.sv
// Shared register-file types and arbitration state for the writeback path.
package types;

  localparam int unsigned REG_ADDRESS_WIDTH = 5;
  localparam int unsigned REG_WIDTH         = 32;
  localparam int unsigned NUM_REGS          = 1 << REG_ADDRESS_WIDTH;

  typedef logic [REG_WIDTH-1:0]         Reg;
  typedef logic [REG_ADDRESS_WIDTH-1:0] RegAddress;

  typedef enum logic {ARB_NORMAL, ARB_FORCE} ArbState;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding long-latency destinations.
// x0 is never busy.
module reg_scoreboard
  import types::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  RegAddress           set_addr,
  input  logic                clr_en,
  input  RegAddress           clr_addr,
  input  RegAddress           query1_addr,
  input  RegAddress           query2_addr,
  input  RegAddress           query3_addr,
  output logic                query1_busy,
  output logic                query2_busy,
  output logic                query3_busy,
  output logic                empty,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy vector: clear the retiring destination, set the newly issued one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign query1_busy = busy_q[query1_addr];
  assign query2_busy = busy_q[query2_addr];
  assign query3_busy = busy_q[query3_addr];
  assign empty       = (busy_q == '0);
  assign busy_vec    = busy_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges the single-cycle pipeline writeback
// with long-latency unit results, tracks outstanding long-unit destinations,
// and forces the pipeline to yield after STARVE_LIMIT blocked cycles.
module writeback_arbiter
  import types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue_valid,
  input  RegAddress issue_rd,
  output logic      issue_ready,
  input  logic      pipe_valid,
  input  RegAddress pipe_rd,
  input  Reg        pipe_data,
  output logic      pipe_stall,
  input  logic      lu_valid,
  input  RegAddress lu_rd,
  input  Reg        lu_data,
  output logic      lu_ready,
  input  RegAddress rd_addr1,
  input  RegAddress rd_addr2,
  output logic      busy1,
  output logic      busy2,
  output logic      sb_empty,
  output logic      rf_we,
  output RegAddress rf_waddr,
  output Reg        rf_wdata
);

  localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);

  ArbState             state_q, state_d;
  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic                pipe_stall_q, pipe_stall_d;
  logic                rf_we_q, rf_we_d;
  RegAddress           rf_waddr_q, rf_waddr_d;
  Reg                  rf_wdata_q, rf_wdata_d;

  logic                pipe_claims;
  logic                pipe_win;
  logic                lu_fire;
  logic                lu_write;
  logic                issue_fire;
  logic                issue_busy;
  logic [NUM_REGS-1:0] busy_vec;

  // Writes to x0 never claim the port, so they cannot block the long unit.
  assign pipe_claims = pipe_valid && (pipe_rd != '0);
  // In the forced cycle the long unit owns the port even if the pipeline misbehaves.
  assign pipe_win    = pipe_claims && (state_q == ARB_NORMAL);
  assign lu_ready    = (state_q == ARB_FORCE) || !pipe_claims;
  assign lu_fire     = lu_valid && lu_ready;
  assign lu_write    = lu_fire && (lu_rd != '0);
  assign issue_ready = !issue_busy;
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (issue_fire),
    .set_addr    (issue_rd),
    .clr_en      (lu_write),
    .clr_addr    (lu_rd),
    .query1_addr (rd_addr1),
    .query2_addr (rd_addr2),
    .query3_addr (issue_rd),
    .query1_busy (busy1),
    .query2_busy (busy2),
    .query3_busy (issue_busy),
    .empty       (sb_empty),
    .busy_vec    (busy_vec)
  );

  // Write-port mux: pipeline has priority unless the long unit is being forced through.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    if (pipe_win) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (lu_write) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lu_rd;
      rf_wdata_d = lu_data;
    end
  end

  // Starvation FSM: count blocked long-unit cycles, then force a one-cycle grant.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pipe_stall_d = 1'b0;
    unique case (state_q)
      ARB_NORMAL: begin
        if (lu_valid && !lu_ready) begin
          wait_cnt_d = wait_cnt_q + CntWidth'(1);
          if (wait_cnt_d == CntWidth'(STARVE_LIMIT)) begin
            state_d      = ARB_FORCE;
            pipe_stall_d = 1'b1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      ARB_FORCE: begin
        state_d    = ARB_NORMAL;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ARB_NORMAL;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State, stall and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_NORMAL;
      wait_cnt_q   <= '0;
      pipe_stall_q <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pipe_stall_q <= pipe_stall_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign pipe_stall = pipe_stall_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  // Protocol checks on the upstream producers.
  pipe_not_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
    pipe_valid |-> !busy_vec[pipe_rd]);
  pipe_not_stalled_a: assert property (@(posedge clk) disable iff (!rst_n)
    pipe_valid |-> !pipe_stall_q);
  lu_dest_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
    (lu_valid && lu_rd != '0) |-> busy_vec[lu_rd]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter; register-file writes are
// scoreboarded against an expected-write queue.
module tb_writeback_arbiter;
  import types::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      issue_valid;
  RegAddress issue_rd;
  logic      issue_ready;
  logic      pipe_valid;
  RegAddress pipe_rd;
  Reg        pipe_data;
  logic      pipe_stall;
  logic      lu_valid;
  RegAddress lu_rd;
  Reg        lu_data;
  logic      lu_ready;
  RegAddress rd_addr1;
  RegAddress rd_addr2;
  logic      busy1;
  logic      busy2;
  logic      sb_empty;
  logic      rf_we;
  RegAddress rf_waddr;
  Reg        rf_wdata;

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .pipe_stall  (pipe_stall),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .sb_empty    (sb_empty),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    RegAddress addr;
    Reg        data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rf_write_unexpected: got addr %0d data %h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          n_bad++;
          $display("FAIL rf_write: got addr %0d data %h, required addr %0d data %h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input RegAddress a, input Reg d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_rd    = '0;
    pipe_valid  = 1'b0;
    pipe_rd     = '0;
    pipe_data   = '0;
    lu_valid    = 1'b0;
    lu_rd       = '0;
    lu_data     = '0;
  endtask

  task automatic issue(input RegAddress a);
    issue_valid = 1'b1;
    issue_rd    = a;
    tick();
    issue_valid = 1'b0;
  endtask

  // Pipeline writes rd 2 every cycle while the long unit waits; returns at the
  // start of the forced cycle (pipe_valid already dropped) or after a bound.
  task automatic starve_round(input RegAddress a, input Reg d, output int blocked,
                              output bit seen);
    blocked    = 0;
    seen       = 1'b0;
    lu_valid   = 1'b1;
    lu_rd      = a;
    lu_data    = d;
    pipe_rd    = RegAddress'(2);
    for (int i = 0; i < 20; i++) begin
      if (pipe_stall === 1'b1) begin
        pipe_valid = 1'b0;
        seen       = 1'b1;
        break;
      end
      pipe_valid = 1'b1;
      pipe_data  = Reg'(32'h100 + i);
      expect_write(RegAddress'(2), pipe_data);
      #1;
      n_cmp++;
      if (lu_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL starve_lu_blocked: got lu_ready %b, required 0 (cycle %0d)",
                 lu_ready, i);
      end
      blocked++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rd_addr1 = RegAddress'(5);
    rd_addr2 = RegAddress'(0);
    repeat (2) tick();
    chk("reset_rf_we", rf_we, 0);
    chk("reset_sb_empty", sb_empty, 1);
    chk("reset_pipe_stall", pipe_stall, 0);
    chk("reset_busy1", busy1, 0);
    issue_rd = RegAddress'(5);
    #1;
    chk("reset_issue_ready", issue_ready, 1);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_issue_lu();
    rd_addr1    = RegAddress'(5);
    issue_valid = 1'b1;
    issue_rd    = RegAddress'(5);
    #1;
    chk("issue5_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("issue5_busy1", busy1, 1);
    chk("issue5_sb_empty", sb_empty, 0);
    chk("issue5_ready_again", issue_ready, 0);
    lu_valid = 1'b1;
    lu_rd    = RegAddress'(5);
    lu_data  = 32'hDEADBEEF;
    #1;
    chk("lu5_ready", lu_ready, 1);
    expect_write(RegAddress'(5), 32'hDEADBEEF);
    tick();
    lu_valid = 1'b0;
    #1;
    chk("lu5_rf_we", rf_we, 1);
    chk("lu5_rf_waddr", rf_waddr, 5);
    chk("lu5_rf_wdata", rf_wdata, 32'hDEADBEEF);
    chk("lu5_busy1", busy1, 0);
    tick();
  endtask

  task automatic test_conflict();
    rd_addr1 = RegAddress'(5);
    issue(RegAddress'(5));
    pipe_valid = 1'b1;
    pipe_rd    = RegAddress'(3);
    pipe_data  = 32'd7;
    lu_valid   = 1'b1;
    lu_rd      = RegAddress'(5);
    lu_data    = 32'h0000_1234;
    #1;
    chk("conflict_lu_ready", lu_ready, 0);
    expect_write(RegAddress'(3), 32'd7);
    tick();
    pipe_valid = 1'b0;
    #1;
    chk("conflict_pipe_waddr", rf_waddr, 3);
    chk("conflict_pipe_wdata", rf_wdata, 7);
    chk("conflict_lu_ready_idle", lu_ready, 1);
    expect_write(RegAddress'(5), 32'h0000_1234);
    tick();
    lu_valid = 1'b0;
    #1;
    chk("conflict_lu_waddr", rf_waddr, 5);
    chk("conflict_lu_wdata", rf_wdata, 32'h0000_1234);
    chk("conflict_busy1", busy1, 0);
    tick();
  endtask

  task automatic test_x0();
    issue_valid = 1'b1;
    issue_rd    = RegAddress'(0);
    #1;
    chk("x0_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("x0_sb_empty", sb_empty, 1);
    pipe_valid = 1'b1;
    pipe_rd    = RegAddress'(0);
    pipe_data  = 32'h5555_AAAA;
    #1;
    chk("x0_pipe_lu_ready", lu_ready, 1);
    tick();
    pipe_valid = 1'b0;
    #1;
    chk("x0_pipe_rf_we", rf_we, 0);
    lu_valid = 1'b1;
    lu_rd    = RegAddress'(0);
    lu_data  = 32'h1111_2222;
    #1;
    chk("x0_lu_ready", lu_ready, 1);
    tick();
    lu_valid = 1'b0;
    #1;
    chk("x0_lu_rf_we", rf_we, 0);
    tick();
  endtask

  task automatic test_parallel();
    issue(RegAddress'(5));
    issue_valid = 1'b1;
    issue_rd    = RegAddress'(9);
    lu_valid    = 1'b1;
    lu_rd       = RegAddress'(5);
    lu_data     = 32'hA5A5_0005;
    expect_write(RegAddress'(5), 32'hA5A5_0005);
    tick();
    issue_valid = 1'b0;
    lu_valid    = 1'b0;
    rd_addr1    = RegAddress'(9);
    rd_addr2    = RegAddress'(5);
    #1;
    chk("par_busy9", busy1, 1);
    chk("par_busy5", busy2, 0);
    chk("par_sb_empty", sb_empty, 0);
    lu_valid = 1'b1;
    lu_rd    = RegAddress'(9);
    lu_data  = 32'hA5A5_0009;
    expect_write(RegAddress'(9), 32'hA5A5_0009);
    tick();
    lu_valid = 1'b0;
    #1;
    chk("par_drain_sb_empty", sb_empty, 1);
    tick();
  endtask

  task automatic test_starvation();
    int blocked;
    bit seen;
    for (int r = 0; r < 2; r++) begin
      issue(RegAddress'(5));
      starve_round(RegAddress'(5), Reg'(32'hCAFE_0000 + r), blocked, seen);
      chk("starve_stall_seen", 32'(seen), 1);
      chk("starve_blocked_cycles", blocked, 4);
      #1;
      chk("starve_force_lu_ready", lu_ready, 1);
      expect_write(RegAddress'(5), Reg'(32'hCAFE_0000 + r));
      tick();
      lu_valid = 1'b0;
      #1;
      chk("starve_stall_one_cycle", pipe_stall, 0);
      chk("starve_force_waddr", rf_waddr, 5);
      tick();
    end
  endtask

  task automatic test_midrun_reset();
    int blocked;
    bit seen;
    rd_addr1 = RegAddress'(3);
    rd_addr2 = RegAddress'(7);
    issue(RegAddress'(3));
    issue(RegAddress'(7));
    #1;
    chk("mid_busy3_pre", busy1, 1);
    chk("mid_busy7_pre", busy2, 1);
    starve_round(RegAddress'(3), 32'hBAD0_0003, blocked, seen);
    chk("mid_stall_pre", pipe_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy3", busy1, 0);
    chk("mid_busy7", busy2, 0);
    chk("mid_sb_empty", sb_empty, 1);
    chk("mid_rf_we", rf_we, 0);
    chk("mid_pipe_stall", pipe_stall, 0);
    // Writes in flight are lost with the reset; the long unit flushes too.
    idle_inputs();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_post_rf_we", rf_we, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_issue_lu();
    test_conflict();
    test_x0();
    test_parallel();
    test_starvation();
    test_midrun_reset();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
